// File: rtl/cacheline_burst_adapter.sv
// Converts one 256-bit cache-line request into a 4-beat 64-bit memory burst and
// returns a single-cycle line response; one line transaction in flight at a time.
module cacheline_burst_adapter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BEATS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [BEATS*64-1:0]   line_wdata,
  output logic                  line_resp,
  output logic [BEATS*64-1:0]   line_rdata,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [63:0]           burst_wdata,
  input  logic [63:0]           burst_rdata,
  input  logic                  burst_resp
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  logic [1:0]            r_state;
  logic [1:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BEATS*64-1:0]   r_wline;
  logic [BEATS*64-1:0]   r_rdata;
  // Beats 0..2 are staged here so line_rdata only changes when a read completes.
  logic [(BEATS-1)*64-1:0] r_rbuf;

  logic [7:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_addr_aligned;
  logic                  w_last;

  assign w_off          = {r_cnt, 6'b0};
  assign w_addr_aligned = {line_addr[ADDR_WIDTH-1:5], 5'b0};
  assign w_last         = burst_resp && (r_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rdata <= '0;
      r_rbuf  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (line_write) begin
            r_addr  <= w_addr_aligned;
            r_wline <= line_wdata;
            r_cnt   <= '0;
            r_state <= WRITE;
          end else if (line_read) begin
            r_addr  <= w_addr_aligned;
            r_cnt   <= '0;
            r_state <= READ;
          end
        end
        READ: begin
          if (burst_resp) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
              r_rdata <= {burst_rdata, r_rbuf};
              r_state <= DONE;
            end else begin
              r_rbuf[w_off +: 64] <= burst_rdata;
            end
          end
        end
        WRITE: begin
          if (burst_resp) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from state so an asynchronous reset drops them at once.
  assign burst_read  = (r_state == READ);
  assign burst_write = (r_state == WRITE);
  assign burst_addr  = r_addr;
  assign burst_wdata = (r_state == WRITE) ? r_wline[w_off +: 64] : 64'd0;
  assign line_resp   = (r_state == DONE);
  assign line_rdata  = r_rdata;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench: stimulus queues expected line results and beat data, a memory
// model serves/checks beats, and a monitor compares each line response.
module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         line_read, line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic         line_resp;
  logic [255:0] line_rdata;
  logic         burst_read, burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  cacheline_burst_adapter #(.ADDR_WIDTH(32), .BEATS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_resp   (line_resp),
    .line_rdata  (line_rdata),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_addr  (burst_addr),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_wr;
    logic [255:0] rdata;
    logic [31:0]  addr;
  } exp_t;

  exp_t         sb[$];
  logic [63:0]  rd_beats[$];
  logic [63:0]  wr_beats[$];
  bit           pat[$];
  bit           mode_zero = 1'b0;
  bit           spur = 1'b0;
  int           checks = 0;
  int           failures = 0;
  int           last_ack = 0;
  logic [255:0] model_rdata = '0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: event observed at cycle %0d, required none", nm, cyc);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Memory model: decides acks at the negedge, serves read beats, checks write beats.
  initial begin
    bit r;
    burst_resp  = 1'b0;
    burst_rdata = '0;
    forever begin
      @(negedge clk);
      burst_resp  = 1'b0;
      burst_rdata = {$urandom, $urandom};
      if (!rst_n) continue;
      if (spur) begin
        burst_resp = 1'b1;
        continue;
      end
      if (burst_read || burst_write) begin
        chk("burst_exclusive", burst_read & burst_write, 0);
        if (sb.size() == 0) begin
          flag("burst_without_request");
          continue;
        end
        chk("burst_direction", burst_write, sb[0].is_wr);
        chk("burst_addr", burst_addr, sb[0].addr);
        if (pat.size() > 0) r = pat.pop_front();
        else if (mode_zero) r = 1'b1;
        else r = ($urandom_range(0, 2) != 0);
        if (burst_write) begin
          if (wr_beats.size() == 0) flag("write_extra_beat");
          else begin
            chk("burst_wdata", burst_wdata, wr_beats[0]);
            if (r) void'(wr_beats.pop_front());
          end
        end else if (r) begin
          if (rd_beats.size() == 0) flag("read_extra_beat");
          else burst_rdata = rd_beats.pop_front();
        end
        burst_resp = r;
        if (r) last_ack = cyc;
      end
    end
  end

  // Monitor: every line_resp pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && line_resp) begin
        if (sb.size() == 0) flag("line_resp_unexpected");
        else begin
          e = sb.pop_front();
          chk("line_rdata", line_rdata, e.rdata);
          chk("resp_after_last_ack", cyc, last_ack + 1);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE with the
  // request still asserted, so the caller can chain a back-to-back request.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [255:0] rbeats, output int lat);
    exp_t e;
    int   t0;
    bit   done;
    e.is_wr = wr;
    e.addr  = {addr[31:5], 5'b0};
    if (wr) begin
      for (int k = 0; k < 4; k++) wr_beats.push_back(wd[64*k +: 64]);
      e.rdata = model_rdata;
    end else begin
      for (int k = 0; k < 4; k++) rd_beats.push_back(rbeats[64*k +: 64]);
      model_rdata = rbeats;
      e.rdata     = rbeats;
    end
    sb.push_back(e);
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wd;
    t0   = cyc;
    done = 1'b0;
    lat  = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (burst_read || burst_write) begin
        line_addr  = $urandom;
        line_wdata = rand256();
      end
      if (line_resp) begin
        done = 1'b1;
        lat  = cyc - t0;
      end
    end
    if (!done) begin
      flag("txn_timeout");
      sb.delete();
      rd_beats.delete();
      wr_beats.delete();
      pat.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    line_read  = 1'b0;
    line_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int           lat;
    int           kind;
    exp_t         e;
    logic [255:0] beats;
    line_read  = 1'b0;
    line_write = 1'b0;
    line_addr  = '0;
    line_wdata = '0;

    @(negedge clk);
    chk("reset_burst_rw", {burst_read, burst_write, line_resp}, 0);
    chk("reset_burst_addr", burst_addr, 0);
    chk("reset_burst_wdata", burst_wdata, 0);
    chk("reset_line_rdata", line_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Spurious acks in IDLE must not advance the beat counter.
    spur = 1'b1;
    idle(3);
    spur = 1'b0;
    idle(1);

    mode_zero = 1'b1;
    beats = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b1, 1'b0, 32'h0000_1234, rand256(), beats, lat);
    chk("read_zero_wait_latency", lat, 5);
    chk("read_zero_wait_rdata", line_rdata, beats);
    run_txn(1'b0, 1'b1, 32'hABCD_EF7F, rand256(), '0, lat);
    chk("b2b_write_latency", lat, 5);
    chk("write_keeps_rdata", line_rdata, beats);
    idle(1);
    mode_zero = 1'b0;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_txn(1'b0, 1'b1, 32'h0000_0F00, rand256(), '0, lat);
    chk("write_gap_latency", lat, 8);
    idle(1);

    run_txn(1'b1, 1'b1, 32'h5555_0040, rand256(), rand256(), lat);
    idle(2);

    // Asynchronous reset in the middle of a stalled read.
    beats   = rand256();
    e.is_wr = 1'b0;
    e.addr  = 32'h0000_2000;
    e.rdata = beats;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) rd_beats.push_back(beats[64*k +: 64]);
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    line_read = 1'b1;
    line_addr = 32'h0000_2000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("pre_reset_burst_read", burst_read, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_burst_read", burst_read, 0);
    chk("reset_async_resp", {burst_write, line_resp}, 0);
    chk("reset_async_addr", burst_addr, 0);
    chk("reset_async_rdata", line_rdata, 0);
    line_read = 1'b0;
    sb.delete();
    rd_beats.delete();
    wr_beats.delete();
    pat.delete();
    model_rdata = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    for (int n = 0; n < 40; n++) begin
      kind      = $urandom_range(0, 2);
      mode_zero = ($urandom_range(0, 3) == 0);
      run_txn(kind != 1, kind != 0, $urandom, rand256(), rand256(), lat);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(6);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
